// File: rtl/tap_tempo_meter_if.sv
// Tap-tempo measurement bundle: raw button level in, measured tempo and pulses out.
// The master side is the meter itself; the slave side is the playback/metronome consumer.
`timescale 1ns/1ps
interface tap_tempo_meter_if #(
    parameter int CNT_W = 32
);
    logic             tap_in;
    logic             tap_pulse;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             period_strobe;
    logic [CNT_W-1:0] avg_out;
    logic             avg_valid;
    logic             timeout_pulse;
    logic             beat_tick;

    modport master (
        input  tap_in,
        output tap_pulse, period_out, period_valid, period_strobe,
               avg_out, avg_valid, timeout_pulse, beat_tick
    );

    modport slave (
        output tap_in,
        input  tap_pulse, period_out, period_valid, period_strobe,
               avg_out, avg_valid, timeout_pulse, beat_tick
    );
endinterface

// File: rtl/tap_tempo_meter.sv
// Measures cycles between debounced button taps, keeps a 4-tap running average
// and regenerates a beat_tick pulse train phase-locked to the latest tap.
`timescale 1ns/1ps
module tap_tempo_meter #(
    parameter int CNT_W           = 32,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int TIMEOUT_CYCLES  = 200000000
) (
    input  logic              clk,
    input  logic              rst_n,
    tap_tempo_meter_if.master bus
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SUM_W = CNT_W + 2;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic {IDLE, RUN} state_t;

    logic              sync1_reg, sync2_reg, deb_reg, tap_pulse_reg;
    logic [DB_W-1:0]   db_cnt_reg;
    state_t            state_reg, state_next;
    logic              start, capture, abort;
    logic [CNT_W-1:0]  interval_reg;
    logic [3:0][CNT_W-1:0] hist_reg;
    logic [SUM_W-1:0]  sum_reg, sum_next;
    logic [2:0]        hist_cnt_reg, hist_cnt_next;
    logic              avg_valid_next;
    logic [CNT_W-1:0]  period_out_reg, avg_out_reg;
    logic              period_valid_reg, period_strobe_reg, avg_valid_reg;
    logic              timeout_pulse_reg, beat_tick_reg;
    logic [CNT_W-1:0]  beat_cnt_reg, tempo;
    logic              tempo_on;

    // Synchronizer and debouncer: a level is accepted only after it has been stable long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg     <= 1'b0;
            sync2_reg     <= 1'b0;
            deb_reg       <= 1'b0;
            db_cnt_reg    <= '0;
            tap_pulse_reg <= 1'b0;
        end else begin
            sync1_reg     <= bus.tap_in;
            sync2_reg     <= sync1_reg;
            tap_pulse_reg <= 1'b0;
            if (sync2_reg == deb_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                db_cnt_reg    <= '0;
                deb_reg       <= sync2_reg;
                tap_pulse_reg <= sync2_reg;
            end else begin
                db_cnt_reg <= db_cnt_reg + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (tap_pulse_reg) state_next = RUN;
            RUN:  if (!tap_pulse_reg && interval_reg == TIMEOUT) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start   = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        case (state_reg)
            IDLE: start = tap_pulse_reg;
            RUN: begin
                capture = tap_pulse_reg;
                abort   = !tap_pulse_reg && interval_reg == TIMEOUT;
            end
            default: ;
        endcase
    end

    // interval_reg equals (current cycle - last tap cycle) while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 interval_reg <= '0;
        else if (start || capture)  interval_reg <= ONE;
        else if (state_reg == RUN)  interval_reg <= interval_reg + ONE;
    end

    // hist_reg[3] is the oldest entry; it reads 0 until four intervals are held.
    assign sum_next       = sum_reg - SUM_W'(hist_reg[3]) + SUM_W'(interval_reg);
    assign hist_cnt_next  = (hist_cnt_reg == 3'd4) ? 3'd4 : hist_cnt_reg + 3'd1;
    assign avg_valid_next = (hist_cnt_next == 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg          <= '0;
            sum_reg           <= '0;
            hist_cnt_reg      <= '0;
            avg_out_reg       <= '0;
            avg_valid_reg     <= 1'b0;
            period_out_reg    <= '0;
            period_valid_reg  <= 1'b0;
            period_strobe_reg <= 1'b0;
            timeout_pulse_reg <= 1'b0;
        end else begin
            period_strobe_reg <= capture;
            timeout_pulse_reg <= abort;
            if (capture) begin
                hist_reg         <= {hist_reg[2:0], interval_reg};
                sum_reg          <= sum_next;
                hist_cnt_reg     <= hist_cnt_next;
                avg_valid_reg    <= avg_valid_next;
                avg_out_reg      <= avg_valid_next ? sum_next[SUM_W-1:2] : '0;
                period_out_reg   <= interval_reg;
                period_valid_reg <= 1'b1;
            end else if (abort) begin
                hist_reg      <= '0;
                sum_reg       <= '0;
                hist_cnt_reg  <= '0;
                avg_valid_reg <= 1'b0;
                avg_out_reg   <= '0;
            end
        end
    end

    always_comb begin
        tempo    = '0;
        tempo_on = 1'b0;
        if (avg_valid_reg) begin
            tempo    = avg_out_reg;
            tempo_on = 1'b1;
        end else if (period_valid_reg) begin
            tempo    = period_out_reg;
            tempo_on = 1'b1;
        end
    end

    // A capture re-phases the generator; >= keeps it ticking if the period shrinks mid-count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_tick_reg <= 1'b0;
            beat_cnt_reg  <= '0;
        end else if (capture) begin
            beat_tick_reg <= 1'b1;
            beat_cnt_reg  <= ONE;
        end else if (!tempo_on) begin
            beat_tick_reg <= 1'b0;
            beat_cnt_reg  <= '0;
        end else if (beat_cnt_reg >= tempo) begin
            beat_tick_reg <= 1'b1;
            beat_cnt_reg  <= ONE;
        end else begin
            beat_tick_reg <= 1'b0;
            beat_cnt_reg  <= beat_cnt_reg + ONE;
        end
    end

    assign bus.tap_pulse     = tap_pulse_reg;
    assign bus.period_out    = period_out_reg;
    assign bus.period_valid  = period_valid_reg;
    assign bus.period_strobe = period_strobe_reg;
    assign bus.avg_out       = avg_out_reg;
    assign bus.avg_valid     = avg_valid_reg;
    assign bus.timeout_pulse = timeout_pulse_reg;
    assign bus.beat_tick     = beat_tick_reg;
endmodule

// File: tb/tb_tap_tempo_meter.sv
// Directed bench for tap_tempo_meter with CNT_W=16, DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=1000.
`timescale 1ns/1ps
module tb_tap_tempo_meter;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    int   tap_cnt = 0, strobe_cnt = 0, to_cnt = 0;
    int   last_tap_cyc = 0, last_strobe_cyc = 0, last_to_cyc = 0;
    int   beat_q[$];
    logic [5:0] flags;

    tap_tempo_meter_if #(.CNT_W(16)) bus ();

    tap_tempo_meter #(
        .CNT_W(16),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign flags = {bus.tap_pulse, bus.period_valid, bus.period_strobe,
                    bus.avg_valid, bus.timeout_pulse, bus.beat_tick};

    // Event log, sampled on the inactive edge.
    always @(negedge clk) begin
        if (bus.tap_pulse)     begin tap_cnt++;    last_tap_cyc = cyc;    end
        if (bus.period_strobe) begin strobe_cnt++; last_strobe_cyc = cyc; end
        if (bus.timeout_pulse) begin to_cnt++;     last_to_cyc = cyc;     end
        if (bus.beat_tick)     beat_q.push_back(cyc);
    end

    task automatic check(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press for 8 cycles; the next press starts exactly n cycles after this one.
    task automatic press(input int n);
        bus.tap_in = 1'b1;
        wait_cycles(8);
        bus.tap_in = 1'b0;
        wait_cycles(n - 8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        beat_q.delete();
    endtask

    // First beat at the latest strobe, then two more spaced p apart.
    task automatic check_beats(input string tag, input int p);
        int idx = -1;
        int ok;
        for (int i = 0; i < beat_q.size(); i++)
            if (idx < 0 && beat_q[i] >= last_strobe_cyc) idx = i;
        ok = (idx >= 0 && idx + 2 < beat_q.size()) ? 1 : 0;
        check({tag, "_present"}, ok, 1);
        if (ok == 1) begin
            check({tag, "_phase"}, beat_q[idx], last_strobe_cyc);
            check({tag, "_per1"}, beat_q[idx+1] - beat_q[idx], p);
            check({tag, "_per2"}, beat_q[idx+2] - beat_q[idx+1], p);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, s0, o0, fb;
        bus.tap_in = 1'b0;
        rst_n = 1'b0;
        wait_cycles(3);
        check("rst_flags", int'(flags), 0);
        check("rst_period", int'(bus.period_out), 0);
        check("rst_avg", int'(bus.avg_out), 0);
        rst_n = 1'b1;
        wait_cycles(2);

        // 1: reset in the middle of a run
        press(200);
        press(200);
        check("t1_pre_valid", int'(bus.period_valid), 1);
        rst_n = 1'b0;
        #2;
        check("t1_mid_flags", int'(flags), 0);
        check("t1_mid_period", int'(bus.period_out), 0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(5);
        check("t1_rel_flags", int'(flags), 0);
        check("t1_rel_period", int'(bus.period_out), 0);
        t0 = tap_cnt; s0 = strobe_cnt;
        press(20);
        check("t1_first_tap", tap_cnt - t0, 1);
        check("t1_no_strobe", strobe_cnt - s0, 0);

        // 2: glitch rejection and bounce inside a long press
        do_reset();
        t0 = tap_cnt;
        bus.tap_in = 1'b1; wait_cycles(3);
        bus.tap_in = 1'b0; wait_cycles(10);
        check("t2_glitch", tap_cnt - t0, 0);
        bus.tap_in = 1'b1; wait_cycles(6);
        bus.tap_in = 1'b0; wait_cycles(2);
        bus.tap_in = 1'b1; wait_cycles(6);
        bus.tap_in = 1'b0; wait_cycles(10);
        check("t2_long_press", tap_cnt - t0, 1);

        // 3: two taps 200 apart
        do_reset();
        s0 = strobe_cnt;
        press(200);
        press(200);
        wait_cycles(450);
        check("t3_strobes", strobe_cnt - s0, 1);
        check("t3_strobe_lat", last_strobe_cyc - last_tap_cyc, 1);
        check("t3_period", int'(bus.period_out), 200);
        check("t3_pvalid", int'(bus.period_valid), 1);
        check("t3_avalid", int'(bus.avg_valid), 0);
        check_beats("t3_beat", 200);

        // 4: intervals 100, 200, 300, 400, then 500
        do_reset();
        press(100);
        press(200);
        press(300);
        press(400);
        press(500);
        check("t4_period400", int'(bus.period_out), 400);
        check("t4_avg250", int'(bus.avg_out), 250);
        check("t4_avalid", int'(bus.avg_valid), 1);
        o0 = to_cnt;
        press(800);
        check("t4_period500", int'(bus.period_out), 500);
        check("t4_avg350", int'(bus.avg_out), 350);
        check_beats("t4_beat", 350);

        // 5: timeout 1001 cycles after the last tap
        wait_cycles(700);
        check("t5_timeouts", to_cnt - o0, 1);
        check("t5_to_cyc", last_to_cyc - last_tap_cyc, 1001);
        check("t5_avalid", int'(bus.avg_valid), 0);
        check("t5_avg_zero", int'(bus.avg_out), 0);
        check("t5_period_kept", int'(bus.period_out), 500);
        check("t5_pvalid_kept", int'(bus.period_valid), 1);
        fb = -1;
        foreach (beat_q[i]) if (fb < 0 && beat_q[i] > last_to_cyc) fb = beat_q[i] - last_to_cyc;
        check("t5_fallback_beat", fb, 200);

        // 5b: interval of exactly TIMEOUT_CYCLES is accepted
        do_reset();
        o0 = to_cnt; s0 = strobe_cnt;
        press(1000);
        press(20);
        check("t5_edge_period", int'(bus.period_out), 1000);
        check("t5_edge_strobe", strobe_cnt - s0, 1);
        check("t5_edge_no_to", to_cnt - o0, 0);
        wait_cycles(1100);
        check("t5_edge_timeout", to_cnt - o0, 1);

        // 6: restart after timeout
        s0 = strobe_cnt;
        press(150);
        check("t6_first_no_strobe", strobe_cnt - s0, 0);
        press(400);
        check("t6_strobe", strobe_cnt - s0, 1);
        check("t6_period", int'(bus.period_out), 150);
        check("t6_avalid", int'(bus.avg_valid), 0);
        check_beats("t6_beat", 150);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/tap_tempo_meter.md
Name: tap_tempo_meter

Overview:
Consumer-side counterpart to the fixed tick prescaler. It measures the interval between debounced user taps on a button in clk cycles and reports the last interval and a 4-tap running average. It also regenerates a beat_tick pulse train at the measured tempo. It sits between the tempo button input and the piano playback/metronome logic, replacing the hard-coded beat rate.

Parameters:
CNT_W, 32, width of interval counter and period outputs
DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a level change on tap_in
TIMEOUT_CYCLES, 200000000, maximum accepted interval; a longer gap aborts the measurement

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tap_in  in  1  raw button level, asynchronous to clk
tap_pulse  out  1  1-cycle pulse per accepted (debounced rising-edge) tap
period_out  out  CNT_W  last measured interval in clk cycles
period_valid  out  1  period_out holds a measured value
period_strobe  out  1  1-cycle pulse when period_out/avg_out update
avg_out  out  CNT_W  mean of last 4 intervals (floor)
avg_valid  out  1  4 intervals collected since last timeout/reset
timeout_pulse  out  1  1-cycle pulse when a measurement aborts
beat_tick  out  1  1-cycle pulse every tempo period

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All state resets to 0, FSM to IDLE, debounced level to 0. All outputs are 0 during and after reset.
- Input path: 2-flop synchronizer, then debouncer.
  - Debounced level changes only after the synced level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - tap_pulse is registered and fires on the debounced 0->1 transition.
  - Falling edges produce no event.
- FSM IDLE:
  - On tap_pulse: go to RUN, start the interval count.
  - No period update.
- FSM RUN:
  - interval = cycles between consecutive tap_pulse assertions (t1 - t0).
  - On tap_pulse with interval <= TIMEOUT_CYCLES: capture, stay in RUN, restart the count from this tap.
  - If no tap by cycle t0+TIMEOUT_CYCLES: at cycle t0+TIMEOUT_CYCLES+1 assert timeout_pulse and go to IDLE. History count clears (avg_valid=0, sum=0); period_out and period_valid are retained.
  - A tap at exactly t0+TIMEOUT_CYCLES is accepted.
- Capture, applied on the cycle after tap_pulse:
  - period_out <= interval, period_valid <= 1, period_strobe = 1.
  - 4-entry history shift register; sum is CNT_W+2 bits, sum <= sum - oldest + interval (oldest=0 until full).
  - hist_cnt saturates at 4. avg_valid <= (hist_cnt_after == 4). avg_out <= sum_new >> 2.
  - avg_out is undefined-but-stable (held 0) while avg_valid=0.
- beat_tick:
  - Tempo period P = avg_out if avg_valid, else period_out if period_valid, else generator off (beat_tick=0).
  - beat_tick is asserted on the period_strobe cycle (phase aligned to the tap), then every P cycles.
  - Each period_strobe re-phases the generator with the new P.
  - Timeout does not stop beat_tick if period_valid remains 1 (it falls back to period_out).
- Simultaneous events: timeout and tap are mutually exclusive by definition. A period_strobe and a pending beat_tick coincide into a single pulse.
- Counter never wraps: it stops at TIMEOUT_CYCLES+1 (requires CNT_W large enough; TIMEOUT_CYCLES < 2^CNT_W - 1).
- Reset mid-operation clears history, FSM and outputs immediately; no pulse is emitted on release.

Test Plan:
(bench params: CNT_W=16, DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=1000)
1. Assert rst_n=0 mid-run, then release -> every output 0, and the first tap afterwards gives no period_strobe (IDLE).
2. tap_in high 3 cycles then low, then high 12 cycles -> no tap_pulse for the glitch; exactly one tap_pulse for the long press; 2-cycle low bounce inside the press gives no extra pulse.
3. Taps spaced 200 cycles (2 taps) -> period_strobe once, period_out=200, period_valid=1, avg_valid=0, beat_tick at strobe and every 200 cycles after.
4. Taps with intervals 100, 200, 300, 400 -> after 4th interval avg_out=250, avg_valid=1. Further interval 500 -> avg_out=350, period_out=500, beat_tick period 350.
5. Tap then 1001 idle cycles -> timeout_pulse at t0+1001, avg_valid=0, period_out retained. Separate run: interval of exactly 1000 -> accepted, period_out=1000.
6. After timeout, two taps 150 apart -> the first gives no strobe, the second gives period_out=150, avg_valid=0, beat_tick re-phased to a 150-cycle period.
